// File: rtl/regfile_mp_if.sv
// regfile_mp_if: read, write, scoreboard and clear signals of the multi-port register file.
interface regfile_mp_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 3
);
    logic [ADDR_W-1:0]   r0addr, r1addr, waddr, sb_addr;
    logic [DATA_W-1:0]   r0data, r1data, wdata;
    logic [DATA_W/8-1:0] wmask;
    logic                r0busy, r1busy, wena, sb_set, clr_req, clr_busy;
    modport master (
        output r0addr, r1addr, wena, waddr, wdata, wmask, sb_set, sb_addr, clr_req,
        input  r0data, r1data, r0busy, r1busy, clr_busy
    );
    modport slave (
        input  r0addr, r1addr, wena, waddr, wdata, wmask, sb_set, sb_addr, clr_req,
        output r0data, r1data, r0busy, r1busy, clr_busy
    );
endinterface

// File: rtl/regfile_mp.sv
// regfile_mp: 2-read/1-write register file with byte masks, write forwarding,
// a pending-write scoreboard and a one-register-per-cycle clear sweep.
module regfile_mp #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 3,
    parameter int BYPASS = 1
) (
    input logic         clk,
    input logic         reset,
    regfile_mp_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int NB    = DATA_W / 8;
    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_CLEAR = 1'b1;

    logic [0:0]        r_state;
    logic [ADDR_W-1:0] r_idx;
    logic [DATA_W-1:0] r_regs [DEPTH];
    logic [DEPTH-1:0]  r_pend;
    logic [DATA_W-1:0] w_bmask, w_merge;
    logic [DEPTH-1:0]  w_pend_nxt;
    logic              w_idle, w_hit0, w_hit1;

    for (genvar b = 0; b < NB; b++) begin : g_bmask
        assign w_bmask[8*b +: 8] = {8{bus.wmask[b]}};
    end

    assign w_idle  = r_state == S_IDLE;
    assign w_merge = (bus.wdata & w_bmask) | (r_regs[bus.waddr] & ~w_bmask);
    assign w_hit0  = (BYPASS != 0) && w_idle && bus.wena && (bus.waddr == bus.r0addr);
    assign w_hit1  = (BYPASS != 0) && w_idle && bus.wena && (bus.waddr == bus.r1addr);

    assign bus.r0data   = w_hit0 ? w_merge : r_regs[bus.r0addr];
    assign bus.r1data   = w_hit1 ? w_merge : r_regs[bus.r1addr];
    assign bus.r0busy   = r_pend[bus.r0addr] & ~w_hit0;
    assign bus.r1busy   = r_pend[bus.r1addr] & ~w_hit1;
    assign bus.clr_busy = r_state == S_CLEAR;

    // set is applied after the write's clear so a same-address set wins
    assign w_pend_nxt = (r_pend & ~(DEPTH'(bus.wena) << bus.waddr)) | (DEPTH'(bus.sb_set) << bus.sb_addr);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_pend  <= '0;
            for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
        end else if (w_idle) begin
            if (bus.wena) r_regs[bus.waddr] <= w_merge;
            r_pend <= w_pend_nxt;
            if (bus.clr_req) begin
                r_state <= S_CLEAR;
                r_idx   <= '0;
            end
        end else begin
            r_regs[r_idx] <= '0;
            r_pend[r_idx] <= 1'b0;
            r_idx         <= r_idx + 1'b1;
            if (r_idx == ADDR_W'(DEPTH - 1)) r_state <= S_IDLE;
        end
    end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: randomized and directed checks of regfile_mp against an array-based model,
// with BYPASS=1 and BYPASS=0 copies sharing stimulus and a 32-bit/16-entry copy.
module tb_regfile_mp;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    regfile_mp_if #(.DATA_W(64), .ADDR_W(3)) ifm ();
    regfile_mp_if #(.DATA_W(64), .ADDR_W(3)) ifn ();
    regfile_mp_if #(.DATA_W(32), .ADDR_W(4)) ifp ();

    regfile_mp #(.DATA_W(64), .ADDR_W(3), .BYPASS(1)) u_dut (.clk(clk), .reset(reset), .bus(ifm));
    regfile_mp #(.DATA_W(64), .ADDR_W(3), .BYPASS(0)) u_nb  (.clk(clk), .reset(reset), .bus(ifn));
    regfile_mp #(.DATA_W(32), .ADDR_W(4), .BYPASS(1)) u_p   (.clk(clk), .reset(reset), .bus(ifp));

    assign ifn.r0addr  = ifm.r0addr;
    assign ifn.r1addr  = ifm.r1addr;
    assign ifn.wena    = ifm.wena;
    assign ifn.waddr   = ifm.waddr;
    assign ifn.wdata   = ifm.wdata;
    assign ifn.wmask   = ifm.wmask;
    assign ifn.sb_set  = ifm.sb_set;
    assign ifn.sb_addr = ifm.sb_addr;
    assign ifn.clr_req = ifm.clr_req;

    int n_cmp = 0;
    int n_err = 0;

    logic [63:0] m_mem [8];
    bit          m_pend [8];
    bit          m_clr;
    int          m_pos;

    function automatic logic [63:0] m_merge(logic [63:0] o, logic [63:0] d, logic [7:0] m);
        logic [63:0] r = o;
        for (int i = 0; i < 8; i++) if (m[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    function automatic bit m_hit(int a, bit byp);
        return byp && !m_clr && ifm.wena && (int'(ifm.waddr) == a);
    endfunction

    function automatic logic [63:0] exp_data(int a, bit byp);
        return m_hit(a, byp) ? m_merge(m_mem[a], ifm.wdata, ifm.wmask) : m_mem[a];
    endfunction

    function automatic logic exp_busy(int a, bit byp);
        return m_pend[a] && !m_hit(a, byp);
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 8; i++) begin
            m_mem[i]  = '0;
            m_pend[i] = 1'b0;
        end
        m_clr = 1'b0;
        m_pos = 0;
    endtask

    task automatic m_update();
        if (m_clr) begin
            m_mem[m_pos]  = '0;
            m_pend[m_pos] = 1'b0;
            m_pos++;
            if (m_pos == 8) m_clr = 1'b0;
        end else begin
            if (ifm.wena) begin
                m_mem[ifm.waddr]  = m_merge(m_mem[ifm.waddr], ifm.wdata, ifm.wmask);
                m_pend[ifm.waddr] = 1'b0;
            end
            if (ifm.sb_set) m_pend[ifm.sb_addr] = 1'b1;
            if (ifm.clr_req) begin
                m_clr = 1'b1;
                m_pos = 0;
            end
        end
    endtask

    task automatic tick();
        m_update();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input bit we, input int wa, input logic [63:0] wd, input logic [7:0] wm,
                         input bit ss, input int sa, input bit cr, input int a0, input int a1);
        ifm.wena    = we;
        ifm.waddr   = 3'(wa);
        ifm.wdata   = wd;
        ifm.wmask   = wm;
        ifm.sb_set  = ss;
        ifm.sb_addr = 3'(sa);
        ifm.clr_req = cr;
        ifm.r0addr  = 3'(a0);
        ifm.r1addr  = 3'(a1);
    endtask

    task automatic idle(input int a0, input int a1);
        drive(0, 0, '0, '0, 0, 0, 0, a0, a1);
    endtask

    task automatic test_reset();
        m_reset();
        idle(0, 7);
        ifp.wena = 0; ifp.waddr = '0; ifp.wdata = '0; ifp.wmask = '0;
        ifp.sb_set = 0; ifp.sb_addr = '0; ifp.clr_req = 0; ifp.r0addr = '0; ifp.r1addr = 4'd15;
        #1;
        n_cmp++;
        if ({ifm.r0data, ifm.r1data, ifm.r0busy, ifm.r1busy, ifm.clr_busy} !== '0) begin
            n_err++;
            $display("FAIL reset_main: got %h/%h busy %b%b clr %b required all 0",
                     ifm.r0data, ifm.r1data, ifm.r0busy, ifm.r1busy, ifm.clr_busy);
        end
        n_cmp++;
        if ({ifp.r0data, ifp.r1data, ifp.r0busy, ifp.r1busy, ifp.clr_busy} !== '0) begin
            n_err++;
            $display("FAIL reset_param: got %h/%h busy %b%b clr %b required all 0",
                     ifp.r0data, ifp.r1data, ifp.r0busy, ifp.r1busy, ifp.clr_busy);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_mask();
        drive(1, 5, 64'h1122334455667788, 8'hFF, 0, 0, 0, 5, 5);
        tick();
        drive(1, 5, 64'hAAAAAAAAAAAAAAAA, 8'h0F, 0, 0, 0, 5, 5);
        #1;
        n_cmp++;
        if (ifm.r0data !== 64'h11223344AAAAAAAA) begin
            n_err++;
            $display("FAIL mask_bypass: got %h required %h", ifm.r0data, 64'h11223344AAAAAAAA);
        end
        n_cmp++;
        if (ifn.r1data !== 64'h1122334455667788) begin
            n_err++;
            $display("FAIL mask_nobypass_old: got %h required %h", ifn.r1data, 64'h1122334455667788);
        end
        tick();
        idle(5, 5);
        #1;
        n_cmp++;
        if (ifm.r0data !== 64'h11223344AAAAAAAA || ifm.r1data !== 64'h11223344AAAAAAAA ||
            ifn.r0data !== 64'h11223344AAAAAAAA) begin
            n_err++;
            $display("FAIL mask_stored: got %h/%h/%h required %h", ifm.r0data, ifm.r1data,
                     ifn.r0data, 64'h11223344AAAAAAAA);
        end
    endtask

    task automatic test_bypass();
        logic [63:0] wd = {$urandom, $urandom};
        logic [63:0] old = m_mem[2];
        drive(1, 2, wd, 8'hFF, 0, 0, 0, 2, 6);
        #1;
        n_cmp++;
        if (ifm.r0data !== wd) begin
            n_err++;
            $display("FAIL bypass_same_cycle: got %h required %h", ifm.r0data, wd);
        end
        n_cmp++;
        if (ifn.r0data !== old) begin
            n_err++;
            $display("FAIL nobypass_same_cycle: got %h required %h", ifn.r0data, old);
        end
        tick();
        idle(2, 2);
        #1;
        n_cmp++;
        if (ifn.r0data !== wd || ifm.r1data !== wd) begin
            n_err++;
            $display("FAIL bypass_after_edge: got %h/%h required %h", ifn.r0data, ifm.r1data, wd);
        end
    endtask

    task automatic test_busy();
        drive(0, 0, '0, '0, 1, 3, 0, 3, 3);
        #1;
        n_cmp++;
        if (ifm.r1busy !== 1'b0) begin
            n_err++;
            $display("FAIL busy_before_set: got %b required 0", ifm.r1busy);
        end
        tick();
        idle(3, 3);
        #1;
        n_cmp++;
        if ({ifm.r0busy, ifm.r1busy, ifn.r1busy} !== 3'b111) begin
            n_err++;
            $display("FAIL busy_after_set: got %b%b%b required 111", ifm.r0busy, ifm.r1busy, ifn.r1busy);
        end
        drive(1, 3, {$urandom, $urandom}, 8'hFF, 1, 3, 0, 3, 3);
        #1;
        n_cmp++;
        if ({ifm.r1busy, ifn.r1busy} !== 2'b01) begin
            n_err++;
            $display("FAIL busy_set_write_cycle: got %b%b required 01", ifm.r1busy, ifn.r1busy);
        end
        tick();
        idle(3, 3);
        #1;
        n_cmp++;
        if ({ifm.r1busy, ifn.r1busy} !== 2'b11) begin
            n_err++;
            $display("FAIL busy_set_wins: got %b%b required 11", ifm.r1busy, ifn.r1busy);
        end
        drive(1, 3, {$urandom, $urandom}, 8'h00, 0, 0, 0, 3, 3);
        #1;
        n_cmp++;
        if ({ifm.r0busy, ifm.r1busy, ifn.r1busy} !== 3'b001) begin
            n_err++;
            $display("FAIL busy_write_cycle: got %b%b%b required 001", ifm.r0busy, ifm.r1busy, ifn.r1busy);
        end
        tick();
        idle(3, 3);
        #1;
        n_cmp++;
        if ({ifm.r1busy, ifn.r1busy} !== 2'b00) begin
            n_err++;
            $display("FAIL busy_cleared_mask0: got %b%b required 00", ifm.r1busy, ifn.r1busy);
        end
    endtask

    task automatic test_clear();
        logic [63:0] wd6 = {$urandom, $urandom};
        int c = 0;
        for (int k = 0; k < 8; k++) begin
            drive(1, k, {$urandom, $urandom}, 8'hFF, 1, k, 0, k, k);
            tick();
        end
        drive(1, 6, wd6, 8'hFF, 1, 6, 1, 6, 6);
        #1;
        n_cmp++;
        if (ifm.clr_busy !== 1'b0) begin
            n_err++;
            $display("FAIL clear_busy_before: got %b required 0", ifm.clr_busy);
        end
        tick();
        while (ifm.clr_busy && c < 20) begin
            drive($urandom_range(0, 1), $urandom_range(0, 7), {$urandom, $urandom}, 8'($urandom),
                  $urandom_range(0, 1), $urandom_range(0, 7), 1, (c > 0) ? c - 1 : 6, c % 8);
            #1;
            n_cmp++;
            if (c == 0 && (ifm.r0data !== wd6 || ifm.r0busy !== 1'b1)) begin
                n_err++;
                $display("FAIL clear_pre_write_kept: got %h busy %b required %h busy 1", ifm.r0data, ifm.r0busy, wd6);
            end else if (c > 0 && (ifm.r0data !== '0 || ifm.r0busy !== 1'b0)) begin
                n_err++;
                $display("FAIL clear_swept_reg%0d: got %h busy %b required 0", c - 1, ifm.r0data, ifm.r0busy);
            end
            n_cmp++;
            if (ifm.r1data !== exp_data(c % 8, 1) || ifm.r1busy !== exp_busy(c % 8, 1) || ifm.clr_busy !== m_clr) begin
                n_err++;
                $display("FAIL clear_pending_reg%0d: got %h busy %b required %h busy %b", c % 8,
                         ifm.r1data, ifm.r1busy, exp_data(c % 8, 1), exp_busy(c % 8, 1));
            end
            tick();
            c++;
        end
        n_cmp++;
        if (c != 8) begin
            n_err++;
            $display("FAIL clear_cycles: got %0d required 8", c);
        end
        for (int k = 0; k < 8; k++) begin
            idle(k, 7 - k);
            #1;
            n_cmp++;
            if ({ifm.r0data, ifm.r0busy, ifn.r1data, ifn.r1busy, ifm.clr_busy} !== '0) begin
                n_err++;
                $display("FAIL clear_result_reg%0d: got %h busy %b required 0", k, ifm.r0data, ifm.r0busy);
            end
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 400; t++) begin
            int a0 = $urandom_range(0, 7);
            int a1 = ($urandom_range(0, 3) == 0) ? a0 : $urandom_range(0, 7);
            drive($urandom_range(0, 1), $urandom_range(0, 7), {$urandom, $urandom}, 8'($urandom),
                  $urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 39) == 0, a0, a1);
            #1;
            n_cmp++;
            if ({ifm.r0data, ifm.r1data, ifm.r0busy, ifm.r1busy, ifm.clr_busy} !==
                {exp_data(a0, 1), exp_data(a1, 1), exp_busy(a0, 1), exp_busy(a1, 1), m_clr}) begin
                n_err++;
                $display("FAIL rand_bypass t=%0d: got %h %h %b%b%b required %h %h %b%b%b", t,
                         ifm.r0data, ifm.r1data, ifm.r0busy, ifm.r1busy, ifm.clr_busy,
                         exp_data(a0, 1), exp_data(a1, 1), exp_busy(a0, 1), exp_busy(a1, 1), m_clr);
            end
            n_cmp++;
            if ({ifn.r0data, ifn.r1data, ifn.r0busy, ifn.r1busy, ifn.clr_busy} !==
                {exp_data(a0, 0), exp_data(a1, 0), exp_busy(a0, 0), exp_busy(a1, 0), m_clr}) begin
                n_err++;
                $display("FAIL rand_nobypass t=%0d: got %h %h %b%b%b required %h %h %b%b%b", t,
                         ifn.r0data, ifn.r1data, ifn.r0busy, ifn.r1busy, ifn.clr_busy,
                         exp_data(a0, 0), exp_data(a1, 0), exp_busy(a0, 0), exp_busy(a1, 0), m_clr);
            end
            tick();
        end
        for (int t = 0; t < 10 && m_clr; t++) begin
            idle(0, 0);
            tick();
        end
    endtask

    task automatic test_reset_mid();
        drive(1, 5, {$urandom, $urandom} | 64'h1, 8'hFF, 1, 7, 0, 5, 7);
        tick();
        drive(0, 0, '0, '0, 0, 0, 1, 5, 7);
        tick();
        repeat (3) begin
            idle(5, 7);
            tick();
        end
        n_cmp++;
        if (ifm.clr_busy !== 1'b1) begin
            n_err++;
            $display("FAIL midreset_sweeping: got %b required 1", ifm.clr_busy);
        end
        #2 reset = 1'b0;
        #1;
        m_reset();
        n_cmp++;
        if ({ifm.r0data, ifm.r1data, ifm.r0busy, ifm.r1busy, ifm.clr_busy,
             ifn.r0data, ifn.r1busy, ifn.clr_busy} !== '0) begin
            n_err++;
            $display("FAIL midreset_immediate: got %h/%h busy %b%b clr %b required all 0",
                     ifm.r0data, ifm.r1data, ifm.r0busy, ifm.r1busy, ifm.clr_busy);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            idle(k, k);
            #1;
            n_cmp++;
            if ({ifm.r0data, ifm.r1busy, ifm.clr_busy} !== '0) begin
                n_err++;
                $display("FAIL midreset_after_reg%0d: got %h busy %b clr %b required 0",
                         k, ifm.r0data, ifm.r1busy, ifm.clr_busy);
            end
        end
    endtask

    task automatic test_param();
        int c = 0;
        ifp.wena = 1; ifp.waddr = 4'd15; ifp.wdata = 32'hDEADBEEF; ifp.wmask = 4'hF;
        ifp.r0addr = 4'd15; ifp.r1addr = 4'd15;
        #1;
        n_cmp++;
        if (ifp.r0data !== 32'hDEADBEEF) begin
            n_err++;
            $display("FAIL param_bypass15: got %h required %h", ifp.r0data, 32'hDEADBEEF);
        end
        @(posedge clk); @(negedge clk);
        ifp.wdata = 32'h11223344; ifp.wmask = 4'b0101; ifp.sb_set = 1; ifp.sb_addr = 4'd15;
        @(posedge clk); @(negedge clk);
        ifp.wena = 0; ifp.sb_set = 0;
        #1;
        n_cmp++;
        if (ifp.r0data !== 32'hDE22BE44 || ifp.r1busy !== 1'b1) begin
            n_err++;
            $display("FAIL param_mask15: got %h busy %b required %h busy 1", ifp.r0data, ifp.r1busy, 32'hDE22BE44);
        end
        ifp.clr_req = 1;
        @(posedge clk); @(negedge clk);
        ifp.clr_req = 0;
        while (ifp.clr_busy && c < 40) begin
            @(posedge clk); @(negedge clk);
            c++;
        end
        n_cmp++;
        if (c != 16) begin
            n_err++;
            $display("FAIL param_sweep_cycles: got %0d required 16", c);
        end
        #1;
        n_cmp++;
        if (ifp.r0data !== '0 || ifp.r0busy !== 1'b0) begin
            n_err++;
            $display("FAIL param_cleared15: got %h busy %b required 0", ifp.r0data, ifp.r0busy);
        end
    endtask

    initial begin
        test_reset();
        test_mask();
        test_bypass();
        test_busy();
        test_clear();
        test_random();
        test_reset_mid();
        test_param();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL provide parameter DATA_W, default 64, register width in bits; legal values are multiples of 8, from 8 to 128.
REQ-002 SHALL provide parameter ADDR_W, default 3, address width; DEPTH = 2**ADDR_W registers.
REQ-003 SHALL provide parameter BYPASS, default 1, enabling write-to-read forwarding (0 = disabled).
REQ-004 SHALL use one clock and an asynchronous active-low reset; ports are named clk and reset.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 reset  input  1  asynchronous active-low reset; 0 = reset asserted.
REQ-007 r0addr  input  ADDR_W  read port 0 address.
REQ-008 r1addr  input  ADDR_W  read port 1 address.
REQ-009 r0data  output  DATA_W  read port 0 data, combinational.
REQ-010 r1data  output  DATA_W  read port 1 data, combinational.
REQ-011 r0busy  output  1  pending-write flag for r0addr, combinational.
REQ-012 r1busy  output  1  pending-write flag for r1addr, combinational.
REQ-013 wena  input  1  write enable.
REQ-014 waddr  input  ADDR_W  write address.
REQ-015 wdata  input  DATA_W  write data.
REQ-016 wmask  input  DATA_W/8  byte enables; bit i writes wdata[8i+7:8i].
REQ-017 sb_set  input  1  allocate pending (scoreboard) bit.
REQ-018 sb_addr  input  ADDR_W  register whose pending bit is set.
REQ-019 clr_req  input  1  request a sequential clear of the whole file.
REQ-020 clr_busy  output  1  high while a clear sweep is in progress.

Function
REQ-021 Write: when wena=1 and FSM=IDLE, each byte i of regs[waddr] with wmask[i]=1 SHALL take wdata at the rising edge; unmasked bytes hold.
REQ-022 Read: rNdata SHALL equal regs[rNaddr], with no read latency.
REQ-023 Bypass (BYPASS=1, FSM=IDLE, wena=1, waddr==rNaddr): rNdata SHALL equal the merge of wdata on masked bytes and regs[rNaddr] on unmasked bytes, in the same cycle.
REQ-024 With BYPASS=0, or FSM=CLEAR, rNdata SHALL show stored contents only.
REQ-025 Scoreboard: a DEPTH-bit pending vector; sb_set=1 (IDLE) SHALL set pending[sb_addr]; wena=1 (IDLE) SHALL clear pending[waddr] for any wmask value, including 0.
REQ-026 When sb_set and wena target the same address in the same cycle, set SHALL win (pending=1 after the edge).
REQ-027 rNbusy SHALL equal pending[rNaddr]; with BYPASS=1 it SHALL be forced to 0 while a bypass hit on that port is active.
REQ-028 FSM states: IDLE, CLEAR. In IDLE, clr_req=1 goes to CLEAR and loads the index counter with 0.
REQ-029 In CLEAR, each cycle SHALL zero regs[idx] and pending[idx], then increment idx; when idx==DEPTH-1, the FSM returns to IDLE at that edge.
REQ-030 A sweep SHALL take exactly DEPTH cycles; clr_busy=1 exactly while FSM=CLEAR and is registered.
REQ-031 In CLEAR, wena, sb_set and clr_req SHALL be ignored and their effects discarded, not queued.
REQ-032 clr_req in IDLE together with wena/sb_set: the write and set SHALL take effect at that edge and the sweep SHALL start next cycle, so the sweep erases them.
REQ-033 The index counter SHALL be ADDR_W bits and SHALL never address past DEPTH-1.
REQ-034 Two read ports on the same address SHALL return identical data and busy.

Reset
REQ-035 reset=0 SHALL immediately, without a clock, zero all registers and pending bits, force FSM=IDLE, idx=0 and clr_busy=0; r*data and r*busy then read 0.
REQ-036 Reset asserted mid-sweep SHALL abort the sweep; after release the block is in IDLE with everything zero.
REQ-037 Deassertion SHALL be synchronised externally; the block takes its first action at the first rising edge with reset=1.

Verification
REQ-038 Write 0x1122334455667788 to reg 5 with wmask=0xFF, next cycle wmask=0x0F, wdata=0xAAAAAAAAAAAAAAAA -> reg 5 reads 0x11223344AAAAAAAA.
REQ-039 BYPASS=1: wena to reg 2 while r0addr=2 -> r0data shows new data in the same cycle; BYPASS=0 -> old data until the next cycle.
REQ-040 sb_set reg 3 -> r1busy=1 next cycle; same-cycle sb_set+wena on reg 3 -> still 1; wena alone on reg 3 -> busy=0 after the edge (0 during the bypass cycle when BYPASS=1).
REQ-041 Fill all 8 regs, pulse clr_req -> clr_busy high exactly 8 cycles; reg k reads 0 from cycle k+1; wena during the sweep has no effect.
REQ-042 Assert reset=0 at sweep cycle 3, off-edge -> all outputs 0 at once; after release, clr_busy=0 and all regs read 0.
REQ-043 Parameter run DATA_W=32, ADDR_W=4 -> a sweep takes 16 cycles, wmask is 4 bits, and address 15 is writable and readable.
